// File: rtl/vga_timing_gen_if.sv
// Video timing bundle from the generator (master) to the painter and DAC (slave).
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       blank_n;
  logic       line_start;
  logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  modport master (
    output pix_en, x, y, hsync, vsync, blank_n, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input pix_en, x, y, hsync, vsync, blank_n, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing: pixel enable every CLK_DIV clks, x/y counters, syncs/blank registered with zero skew to x/y; no backpressure.
// Optional 8-bit frame counter on the interface when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  vga_timing_gen_if.master        vid_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_en_q, pix_en_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             blank_n_q, blank_n_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]       frame_cnt_q, frame_cnt_d;
`endif

  always_comb begin
    div_cnt_d     = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    pix_en_d      = (div_cnt_q == DIV_LAST);
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en_q) begin
      if (x_q == H_LAST) begin
        x_d          = '0;
        line_start_d = 1'b1;
        if (y_q == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    // Decode from the next coordinates so sync/blank change on the same edge as x/y.
    hsync_d   = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vsync_d   = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
    blank_n_d = (x_d < H_ACT) && (y_d < V_ACT);
`ifdef VGA_FRAME_CNT_EN
    frame_cnt_d = frame_start_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= '0;
      pix_en_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_n_q     <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_en_q      <= pix_en_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_n_q     <= blank_n_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign vid_o.pix_en      = pix_en_q;
  assign vid_o.x           = x_q;
  assign vid_o.y           = y_q;
  assign vid_o.hsync       = hsync_q;
  assign vid_o.vsync       = vsync_q;
  assign vid_o.blank_n     = blank_n_q;
  assign vid_o.line_start  = line_start_q;
  assign vid_o.frame_start = frame_start_q;
`ifdef VGA_FRAME_CNT_EN
  assign vid_o.frame_cnt   = frame_cnt_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster, CLK_DIV=2 and CLK_DIV=1 instances.
// Expected outputs come from a closed-form model of clk count since reset, queued per edge.
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct packed {
    logic       pix_en;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       bn;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if vid_a();
  vga_timing_gen_if vid_b();

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(2))
    dut_a (.clk(clk), .reset(reset), .vid_o(vid_a));
  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(1))
    dut_b (.clk(clk), .reset(reset), .vid_o(vid_b));

  int total = 0;
  int bad   = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  bit   armed = 1'b0;
  int   exp_frames_a = 0;
  int   got_frames_a = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Pixel advances seen after edge n (reset edge is n=0): one per pix_en edge.
  function automatic int unsigned pix_cnt(input int unsigned n, input int unsigned d);
    return (n >= 1) ? (n - 1) / d : 0;
  endfunction

  function automatic exp_t model(input int unsigned n, input int unsigned d);
    exp_t e;
    int unsigned p, pp, xi, yi;
    p  = pix_cnt(n, d);
    pp = (n >= 1) ? pix_cnt(n - 1, d) : 0;
    xi = p % HT;
    yi = (p / HT) % VT;
    e.pix_en = (n >= 1) && (n % d == 0);
    e.x  = 10'(xi);
    e.y  = 10'(yi);
    e.hs = !((xi >= HA + HF) && (xi < HA + HF + HS));
    e.vs = !((yi >= VA + VF) && (yi < VA + VF + VS));
    e.bn = (xi < HA) && (yi < VA);
    e.ls = (p != pp) && (xi == 0);
    e.fs = e.ls && (yi == 0);
`ifdef VGA_FRAME_CNT_EN
    e.fc = 8'((p / (HT * VT)) % 256);
`else
    e.fc = 8'd0;
`endif
    return e;
  endfunction

  task automatic cmp(input string pfx, input exp_t g, input exp_t e);
    check_eq({pfx, ".pix_en"},      32'(g.pix_en), 32'(e.pix_en));
    check_eq({pfx, ".x"},           32'(g.x),      32'(e.x));
    check_eq({pfx, ".y"},           32'(g.y),      32'(e.y));
    check_eq({pfx, ".hsync"},       32'(g.hs),     32'(e.hs));
    check_eq({pfx, ".vsync"},       32'(g.vs),     32'(e.vs));
    check_eq({pfx, ".blank_n"},     32'(g.bn),     32'(e.bn));
    check_eq({pfx, ".line_start"},  32'(g.ls),     32'(e.ls));
    check_eq({pfx, ".frame_start"}, 32'(g.fs),     32'(e.fs));
    check_eq({pfx, ".frame_cnt"},   32'(g.fc),     32'(e.fc));
  endtask

  // Scoreboard producer: each edge yields one expected state per DUT.
  initial begin
    int unsigned n;
    n = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        n = 0;
        armed = 1'b1;
      end else begin
        n = n + 1;
      end
      if (armed) begin
        q_a.push_back(model(n, 2));
        q_b.push_back(model(n, 1));
      end
    end
  end

  // Scoreboard consumer plus sync pulse-width measurement on the CLK_DIV=2 instance.
  initial begin
    exp_t g, e;
    int hs_run, vs_run;
    hs_run = 0;
    vs_run = 0;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        g.pix_en = vid_a.pix_en; g.x = vid_a.x; g.y = vid_a.y;
        g.hs = vid_a.hsync; g.vs = vid_a.vsync; g.bn = vid_a.blank_n;
        g.ls = vid_a.line_start; g.fs = vid_a.frame_start;
`ifdef VGA_FRAME_CNT_EN
        g.fc = vid_a.frame_cnt;
`else
        g.fc = 8'd0;
`endif
        cmp("a", g, e);
        if (e.fs) exp_frames_a++;
        if (vid_a.frame_start === 1'b1) got_frames_a++;
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        g.pix_en = vid_b.pix_en; g.x = vid_b.x; g.y = vid_b.y;
        g.hs = vid_b.hsync; g.vs = vid_b.vsync; g.bn = vid_b.blank_n;
        g.ls = vid_b.line_start; g.fs = vid_b.frame_start;
`ifdef VGA_FRAME_CNT_EN
        g.fc = vid_b.frame_cnt;
`else
        g.fc = 8'd0;
`endif
        cmp("b", g, e);
      end
      if (armed) begin
        if (vid_a.hsync === 1'b0) hs_run++;
        else if (hs_run != 0) begin
          check_eq("a.hsync_low_clks", 32'(hs_run), 32'(HS * 2));
          hs_run = 0;
        end
        if (vid_a.vsync === 1'b0) vs_run++;
        else if (vs_run != 0) begin
          check_eq("a.vsync_low_clks", 32'(vs_run), 32'(VS * HT * 2));
          vs_run = 0;
        end
      end
    end
  end

  initial begin
    int run_clks;
    bit found;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    // Mid-frame reset at a visible, non-sync pixel.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (vid_a.x == 10'd5 && vid_a.y == 10'd3) found = 1'b1;
    end
    check_eq("seek_x5_y3", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`ifdef VGA_FRAME_CNT_EN
    run_clks = 258 * HT * VT * 2 + 50;
`else
    run_clks = 3 * HT * VT * 2 + 50;
`endif
    repeat (run_clks) @(negedge clk);
    check_eq("a.frame_start_count", 32'(got_frames_a), 32'(exp_frames_a));
    check_eq("a.frames_seen_nonzero", 32'(exp_frames_a >= 3), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
